// File: rtl/char_term_ctrl.sv
// Character terminal controller: turns a byte stream into character-buffer writes with cursor, scroll and clear.
// Optional CHAR_TERM_CLEAR_ON_RESET_EN: clear the whole screen right after reset release.
module char_term_ctrl #(
    parameter int COLS      = 80,
    parameter int ROWS      = 24,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           buf_din,
    output logic [ADDR_BITS-1:0] buf_waddr,
    output logic                 buf_wen,
    output logic                 buf_graphic,
    output logic [4:0]           top_row,
    output logic [6:0]           cursor_col,
    output logic [4:0]           cursor_row,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR_LINE,
        CLEAR_ALL
    } state_t;

    localparam logic [ADDR_BITS-1:0] CELL_LAST = ADDR_BITS'(ROWS * COLS - 1);
    localparam logic [ADDR_BITS-1:0] LINE_SPAN = ADDR_BITS'(COLS - 1);
    localparam logic [6:0]           COL_LAST  = 7'(COLS - 1);
    localparam logic [4:0]           ROW_LAST  = 5'(ROWS - 1);
    localparam logic [7:0]           BLANK     = 8'h20;

`ifdef CHAR_TERM_CLEAR_ON_RESET_EN
    localparam logic CLEAR_ON_RESET = 1'b1;
`else
    localparam logic CLEAR_ON_RESET = 1'b0;
`endif

    state_t                 state_q;
    logic                   in_ready_q;
    logic [7:0]             buf_din_q;
    logic [ADDR_BITS-1:0]   buf_waddr_q;
    logic                   buf_wen_q;
    logic                   buf_graphic_q;
    logic [4:0]             top_row_q;
    logic [6:0]             cursor_col_q;
    logic [4:0]             cursor_row_q;
    logic                   busy_q;
    logic                   gmode_q;
    logic [ADDR_BITS-1:0]   clr_last_q;
    logic                   pend_clr_q;

    logic [5:0]             row_raw;
    logic [5:0]             row_phys;
    logic [ADDR_BITS-1:0]   wr_addr_d;
    logic [ADDR_BITS-1:0]   scroll_base_d;
    logic [4:0]             top_row_d;

    always_comb begin
        row_raw  = {1'b0, top_row_q} + {1'b0, cursor_row_q};
        row_phys = (row_raw >= 6'(ROWS)) ? row_raw - 6'(ROWS) : row_raw;
        wr_addr_d = ADDR_BITS'(row_phys) * ADDR_BITS'(COLS) + ADDR_BITS'(cursor_col_q);
        // After a scroll the new bottom physical row is the one that used to be on top.
        scroll_base_d = ADDR_BITS'(top_row_q) * ADDR_BITS'(COLS);
        top_row_d = (top_row_q == ROW_LAST) ? '0 : top_row_q + 5'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            buf_din_q     <= '0;
            buf_waddr_q   <= '0;
            buf_wen_q     <= 1'b0;
            buf_graphic_q <= 1'b0;
            top_row_q     <= '0;
            cursor_col_q  <= '0;
            cursor_row_q  <= '0;
            busy_q        <= 1'b0;
            gmode_q       <= 1'b0;
            clr_last_q    <= '0;
            pend_clr_q    <= CLEAR_ON_RESET;
        end else begin
            buf_wen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (pend_clr_q) begin
                        pend_clr_q    <= 1'b0;
                        state_q       <= CLEAR_ALL;
                        in_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        buf_wen_q     <= 1'b1;
                        buf_din_q     <= BLANK;
                        buf_graphic_q <= 1'b0;
                        buf_waddr_q   <= '0;
                        clr_last_q    <= CELL_LAST;
                    end else if (in_valid && in_ready_q) begin
                        if (in_data >= 8'h20) begin
                            state_q       <= WRITE;
                            in_ready_q    <= 1'b0;
                            buf_wen_q     <= 1'b1;
                            buf_din_q     <= in_data;
                            buf_graphic_q <= gmode_q;
                            buf_waddr_q   <= wr_addr_d;
                        end else begin
                            case (in_data)
                                8'h0D: cursor_col_q <= '0;
                                8'h0A: begin
                                    if (cursor_row_q != ROW_LAST) begin
                                        cursor_row_q <= cursor_row_q + 5'd1;
                                    end else begin
                                        top_row_q     <= top_row_d;
                                        state_q       <= CLEAR_LINE;
                                        in_ready_q    <= 1'b0;
                                        busy_q        <= 1'b1;
                                        buf_wen_q     <= 1'b1;
                                        buf_din_q     <= BLANK;
                                        buf_graphic_q <= 1'b0;
                                        buf_waddr_q   <= scroll_base_d;
                                        clr_last_q    <= scroll_base_d + LINE_SPAN;
                                    end
                                end
                                8'h08: begin
                                    if (cursor_col_q != '0) cursor_col_q <= cursor_col_q - 7'd1;
                                end
                                8'h0E: gmode_q <= 1'b1;
                                8'h0F: gmode_q <= 1'b0;
                                8'h0C: begin
                                    state_q       <= CLEAR_ALL;
                                    in_ready_q    <= 1'b0;
                                    busy_q        <= 1'b1;
                                    buf_wen_q     <= 1'b1;
                                    buf_din_q     <= BLANK;
                                    buf_graphic_q <= 1'b0;
                                    buf_waddr_q   <= '0;
                                    clr_last_q    <= CELL_LAST;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                WRITE: begin
                    if (cursor_col_q != COL_LAST) begin
                        cursor_col_q <= cursor_col_q + 7'd1;
                        state_q      <= IDLE;
                        in_ready_q   <= 1'b1;
                    end else begin
                        cursor_col_q <= '0;
                        if (cursor_row_q != ROW_LAST) begin
                            cursor_row_q <= cursor_row_q + 5'd1;
                            state_q      <= IDLE;
                            in_ready_q   <= 1'b1;
                        end else begin
                            top_row_q     <= top_row_d;
                            state_q       <= CLEAR_LINE;
                            busy_q        <= 1'b1;
                            buf_wen_q     <= 1'b1;
                            buf_din_q     <= BLANK;
                            buf_graphic_q <= 1'b0;
                            buf_waddr_q   <= scroll_base_d;
                            clr_last_q    <= scroll_base_d + LINE_SPAN;
                        end
                    end
                end
                CLEAR_LINE, CLEAR_ALL: begin
                    if (buf_waddr_q == clr_last_q) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        if (state_q == CLEAR_ALL) begin
                            cursor_col_q <= '0;
                            cursor_row_q <= '0;
                            top_row_q    <= '0;
                        end
                    end else begin
                        buf_wen_q   <= 1'b1;
                        buf_waddr_q <= buf_waddr_q + ADDR_BITS'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign buf_din     = buf_din_q;
    assign buf_waddr   = buf_waddr_q;
    assign buf_wen     = buf_wen_q;
    assign buf_graphic = buf_graphic_q;
    assign top_row     = top_row_q;
    assign cursor_col  = cursor_col_q;
    assign cursor_row  = cursor_row_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_char_term_ctrl.sv
// Bench for char_term_ctrl: screen-level model of expected writes and cursor, checked every cycle.
module tb_char_term_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 24;
    localparam int AB   = 11;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    buf_din;
    logic [AB-1:0] buf_waddr;
    logic          buf_wen;
    logic          buf_graphic;
    logic [4:0]    top_row;
    logic [6:0]    cursor_col;
    logic [4:0]    cursor_row;
    logic          busy;

    char_term_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_BITS(AB)) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .buf_din(buf_din), .buf_waddr(buf_waddr),
        .buf_wen(buf_wen), .buf_graphic(buf_graphic), .top_row(top_row),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int addr;
        int din;
        int gr;
        int clr;
    } wr_t;
    wr_t exp_q[$];

    int m_col = 0, m_row = 0, m_top = 0, m_gm = 0;
    int wr_cnt = 0, busy_cnt = 0, stall_cnt = 0;
    int last_addr = 0, last_din = 0, last_gr = 0;
    bit was_up = 1'b0;

    task automatic push_wr(input int a, input int d, input int g, input int c);
        wr_t e;
        e.addr = a; e.din = d; e.gr = g; e.clr = c;
        exp_q.push_back(e);
    endtask

    task automatic model_lf();
        int bottom;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            m_top  = (m_top + 1) % ROWS;
            bottom = (m_top + ROWS - 1) % ROWS;
            for (int i = 0; i < COLS; i++) push_wr(bottom * COLS + i, 32, 0, 1);
        end
    endtask

    task automatic model_byte(input int b);
        if (b >= 32) begin
            push_wr(((m_top + m_row) % ROWS) * COLS + m_col, b, m_gm, 0);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                model_lf();
            end
        end else begin
            case (b)
                13: m_col = 0;
                10: model_lf();
                8:  if (m_col > 0) m_col--;
                14: m_gm = 1;
                15: m_gm = 0;
                12: begin
                    for (int a = 0; a < ROWS * COLS; a++) push_wr(a, 32, 0, 1);
                    m_col = 0; m_row = 0; m_top = 0;
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) was_up = resetn;

    always @(negedge clk) begin
        wr_t e;
        if (!resetn) begin
            chk("wen_in_reset", int'(buf_wen), 0);
        end else begin
            if (in_valid && !in_ready) stall_cnt++;
            if (busy) busy_cnt++;
            if (was_up) chk("ready_vs_wen", int'(in_ready), int'(!buf_wen));
            if (buf_wen) begin
                wr_cnt++;
                last_addr = int'(buf_waddr);
                last_din  = int'(buf_din);
                last_gr   = int'(buf_graphic);
                chk("addr_in_range", int'(int'(buf_waddr) < ROWS * COLS), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", int'(buf_waddr), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(buf_waddr), e.addr);
                    chk("wr_din", int'(buf_din), e.din);
                    chk("wr_graphic", int'(buf_graphic), e.gr);
                    chk("busy_during_write", int'(busy), e.clr);
                end
            end else begin
                chk("busy_idle", int'(busy), 0);
            end
        end
    end

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ctl"}, int'({in_ready, busy, buf_wen, buf_graphic, buf_din}), 0);
        chk({nm, "_addr"}, int'(buf_waddr), 0);
        chk({nm, "_pos"}, int'({top_row, cursor_col, cursor_row}), 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk_reset_outputs("reset_values");
        exp_q.delete();
        m_col = 0; m_row = 0; m_top = 0; m_gm = 0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", int'(in_ready), 1);
    endtask

    // Entered and left 1ns after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_byte(int'(b));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while (!in_ready && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("settle_timeout", 0, 1);
        chk("cursor_col", int'(cursor_col), m_col);
        chk("cursor_row", int'(cursor_row), m_row);
        chk("top_row", int'(top_row), m_top);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b);
        settle();
    endtask

    initial begin
        int w0;
        int found;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_initial");
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_first_cycle", int'(in_ready), 1);
        chk("no_writes_after_release", wr_cnt, 0);

        // 'A' at home
        send(8'h41);
        chk("A_count", wr_cnt, 1);
        chk("A_addr", last_addr, 0);
        chk("A_din", last_din, 8'h41);
        chk("A_graphic", last_gr, 0);
        chk("A_col", int'(cursor_col), 1);

        // row 2 col 5, graphic on/off
        send(8'h0D); send(8'h0A); send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h20);
        send(8'h0E);
        send(8'h61);
        chk("ga_addr", last_addr, 165);
        chk("ga_din", last_din, 8'h61);
        chk("ga_graphic", last_gr, 1);
        send(8'h0F);
        send(8'h62);
        chk("gb_addr", last_addr, 166);
        chk("gb_graphic", last_gr, 0);
        send(8'h08);
        chk("bs_col", int'(cursor_col), 6);
        send(8'h0D); send(8'h08);
        chk("bs_at_zero", int'(cursor_col), 0);
        w0 = wr_cnt;
        send(8'h01); send(8'h1F); send(8'h1B);
        chk("ignored_no_write", wr_cnt - w0, 0);
        send(8'hFF);
        chk("ff_byte_addr", last_addr, 160);
        chk("ff_byte_din", last_din, 8'hFF);

        // 24 line feeds from row 0
        do_reset();
        w0 = wr_cnt;
        for (int i = 0; i < 23; i++) send(8'h0A);
        chk("lf23_row", int'(cursor_row), 23);
        chk("lf23_no_write", wr_cnt - w0, 0);
        busy_cnt = 0;
        send(8'h0A);
        chk("lf24_writes", wr_cnt - w0, 80);
        chk("lf24_busy_cycles", busy_cnt, 80);
        chk("lf24_top", int'(top_row), 1);
        chk("lf24_last_addr", last_addr, 79);

        // auto-wrap on the last row: char first, then scroll
        send(8'h0D);
        for (int i = 0; i < 80; i++) send(8'h21 + 8'(i % 90));
        chk("wrap_scroll_top", int'(top_row), 2);
        chk("wrap_scroll_last", last_addr, 159);

        // 80 bytes on row 0
        do_reset();
        for (int i = 0; i < 80; i++) send(8'h30 + 8'(i % 64));
        chk("row0_last_addr", last_addr, 79);
        chk("row0_col", int'(cursor_col), 0);
        chk("row0_row", int'(cursor_row), 1);

        // form feed with in_valid held through the clear
        w0 = wr_cnt;
        stall_cnt = 0;
        in_data  = 8'h0C;
        in_valid = 1'b1;
        @(posedge clk);
        model_byte(12);
        #1;
        in_data = 8'h5A;
        send_byte(8'h5A);
        settle();
        chk("ff_stall_cycles", stall_cnt, 1920);
        chk("ff_writes", wr_cnt - w0, 1921);
        chk("ff_then_Z_addr", last_addr, 0);
        chk("ff_then_Z_col", int'(cursor_col), 1);

        // reset in the middle of a full clear
        send_byte(8'h0C);
        found = 0;
        for (int n = 0; n < 3000 && found == 0; n++) begin
            @(posedge clk); #1;
            if (buf_wen && int'(buf_waddr) == 500) found = 1;
        end
        chk("reached_addr_500", found, 1);
        #1;
        do_reset();
        w0 = wr_cnt;
        send(8'h41);
        chk("post_abort_writes", wr_cnt - w0, 1);
        chk("post_abort_addr", last_addr, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
